// File: rtl/uart_tx.sv
// UART transmitter: serializes DATA_BITS LSB-first with start, optional parity and 1/2 stop bits.
// Accepts a byte on tx_valid&&tx_ready in IDLE only; each bit lasts baud_div+1 cycles; tx is a flop.
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t                 state;
  logic [DATA_BITS-1:0]   shreg;
  logic [DIV_WIDTH-1:0]   div_q;
  logic [DIV_WIDTH-1:0]   baud_cnt;
  logic [2:0]             bit_idx;
  logic                   par_en_q;
  logic                   par_bit_q;
  logic                   two_stop_q;
  logic                   bit_end;

  assign bit_end = (baud_cnt == div_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      div_q      <= '0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      tx         <= 1'b1;
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state == IDLE) begin
        tx <= 1'b1;
        if (tx_valid && tx_ready) begin
          // Parity is computed up front so the data register can simply shift.
          shreg      <= tx_data;
          div_q      <= baud_div;
          par_en_q   <= parity_en;
          par_bit_q  <= (^tx_data) ^ parity_odd;
          two_stop_q <= two_stop;
          baud_cnt   <= '0;
          bit_idx    <= '0;
          state      <= START;
          tx         <= 1'b0;
          tx_ready   <= 1'b0;
          tx_busy    <= 1'b1;
        end
      end else if (!bit_end) begin
        baud_cnt <= baud_cnt + 1'b1;
      end else begin
        baud_cnt <= '0;
        case (state)
          START: begin
            state   <= DATA;
            tx      <= shreg[0];
            bit_idx <= '0;
          end
          DATA: begin
            if (bit_idx == LAST_BIT) begin
              bit_idx <= '0;
              if (par_en_q) begin
                state <= PARITY;
                tx    <= par_bit_q;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[1];
              shreg   <= shreg >> 1;
            end
          end
          PARITY: begin
            state   <= STOP;
            tx      <= 1'b1;
            bit_idx <= '0;
          end
          STOP: begin
            if (two_stop_q && bit_idx == 3'd0) begin
              bit_idx <= 3'd1;
            end else begin
              state    <= IDLE;
              bit_idx  <= '0;
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
              tx_done  <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

  a_data_bits: assert property (@(posedge clk) (DATA_BITS >= 5) && (DATA_BITS <= 8));
  a_done_idle: assert property (@(posedge clk) disable iff (!rst_n) !(tx_done && tx_busy));
  a_idle_high: assert property (@(posedge clk) disable iff (!rst_n) (state == IDLE) |-> tx);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: table vectors, hand-written corner sequences and random frames,
// each recorded cycle by cycle and compared with a bit-list frame model.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] baud_div;
  logic        parity_en, parity_odd, two_stop;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready, tx, tx_busy, tx_done;

  always #5 clk = ~clk;

  uart_tx #(.DATA_BITS(8), .DIV_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .parity_en(parity_en),
    .parity_odd(parity_odd), .two_stop(two_stop), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy),
    .tx_done(tx_done)
  );

  typedef struct {
    logic [7:0] d;
    int         div;
    bit         pe, po, ts;
    int         cycles;
    int         pbit;
  } vec_t;

  int passed = 0;
  int total  = 0;
  int last_len;
  bit rec[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Frame as a list of line levels, one per clock cycle after acceptance.
  task automatic build_model(input logic [7:0] d, input int div, input bit pe, input bit po,
                             input bit ts, output bit q[$]);
    bit bits[$];
    q = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back((($countones(d) % 2) == 1) ^ po);
    bits.push_back(1'b1);
    if (ts) bits.push_back(1'b1);
    foreach (bits[i]) for (int k = 0; k <= div; k++) q.push_back(bits[i]);
  endtask

  task automatic run_frame(input logic [7:0] d, input int div, input bit pe, input bit po,
                           input bit ts, input bit keep, input int chg_at);
    bit exp_q[$];
    int n = 0, errs = 0, flagerr = 0;
    tx_data = d; baud_div = 16'(div); parity_en = pe; parity_odd = po; two_stop = ts;
    tx_valid = 1'b1;
    check("ready_before_send", tx_ready, 1);
    @(posedge clk);
    @(negedge clk);
    if (!keep) tx_valid = 1'b0;
    rec = {};
    while (tx_done !== 1'b1 && n < 2000) begin
      rec.push_back(tx);
      if (tx_busy !== 1'b1 || tx_ready !== 1'b0 || tx_done !== 1'b0) flagerr++;
      if (n == chg_at) begin
        baud_div  = 16'd7;
        parity_en = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    last_len = n;
    build_model(d, div, pe, po, ts, exp_q);
    check("frame_len", n, exp_q.size());
    for (int i = 0; i < rec.size() && i < exp_q.size(); i++)
      if (rec[i] !== exp_q[i]) errs++;
    check("serial_bits", errs, 0);
    check("busy_ready_in_frame", flagerr, 0);
    check("end_state", {tx, tx_ready, tx_busy, tx_done}, 4'b1101);
    if (!keep) begin
      @(negedge clk);
      check("done_width", {tx_done, tx}, 2'b01);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int bad;
    vecs[0] = '{8'hA5, 3, 1'b0, 1'b0, 1'b0, 40, -1};
    vecs[1] = '{8'h07, 1, 1'b1, 1'b0, 1'b1, 24,  1};
    vecs[2] = '{8'h07, 1, 1'b1, 1'b1, 1'b1, 24,  0};
    vecs[3] = '{8'h00, 0, 1'b0, 1'b0, 1'b0, 10, -1};
    vecs[4] = '{8'hFF, 2, 1'b1, 1'b1, 1'b0, 33,  1};
    vecs[5] = '{8'h80, 4, 1'b1, 1'b0, 1'b1, 60,  1};

    rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; baud_div = '0;
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_hold", {tx, tx_ready, tx_busy, tx_done}, 4'b1100);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_state", {tx, tx_ready, tx_busy, tx_done}, 4'b1100);

    foreach (vecs[i]) begin
      run_frame(vecs[i].d, vecs[i].div, vecs[i].pe, vecs[i].po, vecs[i].ts, 1'b0, -1);
      check("table_len", last_len, vecs[i].cycles);
      if (vecs[i].pbit >= 0 && rec.size() > 9 * (vecs[i].div + 1))
        check("parity_bit", rec[9 * (vecs[i].div + 1)], vecs[i].pbit);
    end

    // Back-to-back with tx_valid held: one idle-high cycle (end_state) then a new start.
    run_frame(8'h55, 0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    run_frame(8'h0F, 0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    check("b2b_start_low", (rec.size() > 0) ? 32'(rec[0]) : 32'hx, 0);

    // Config change during DATA must not affect the frame in flight.
    run_frame(8'h3C, 2, 1'b0, 1'b0, 1'b0, 1'b0, 15);
    check("cfg_change_len", last_len, 30);
    run_frame(8'hC3, 7, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    check("new_cfg_len", last_len, 88);

    // Reset during data bit 4 of an all-zero byte.
    tx_data = 8'h00; baud_div = 16'd3; parity_en = 1'b0; two_stop = 1'b0;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_reset_tx", tx, 0);
    #2 rst_n = 1'b0;
    #1 check("reset_async", {tx, tx_ready, tx_busy, tx_done}, 4'b1100);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (tx_done !== 1'b0 || tx !== 1'b1) bad++;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (tx_done !== 1'b0 || tx !== 1'b1 || tx_ready !== 1'b1) bad++;
    end
    check("no_done_after_abort", bad, 0);
    run_frame(8'h81, 3, 1'b0, 1'b0, 1'b0, 1'b0, -1);

    for (int r = 0; r < 20; r++) begin
      run_frame(8'($urandom), int'($urandom_range(0, 4)), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom_range(0, 1)), -1);
    end
    tx_valid = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART serial transmitter, the outbound counterpart of the synchronized RX path. It accepts parallel bytes over a valid/ready handshake and serializes each one LSB-first onto the tx pin as start, data, optional parity and stop bits, with a runtime baud divisor. Its output is fully registered, so the pin drives glitch-free straight off a flop. It sits in the UART core between the TX FIFO and the pad.

Parameters:
DATA_BITS, 8, payload width per frame (legal 5..8)
DIV_WIDTH, 16, width of baud divisor input

Ports:
clk  input  1  transmit clock; sole clock domain
rst_n  input  1  asynchronous active-low reset
baud_div  input  DIV_WIDTH  bit period minus one, in clk cycles
parity_en  input  1  1 = append parity bit
parity_odd  input  1  1 = odd parity, 0 = even (ignored if parity_en=0)
two_stop  input  1  1 = two stop bits, 0 = one
tx_data  input  DATA_BITS  byte to send
tx_valid  input  1  tx_data valid
tx_ready  output  1  block can accept a byte
tx  output  1  serial line, idle high
tx_busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset is asynchronous and active-low, and one clock is used throughout.
- Reset values: tx=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, all counters 0.
- All outputs are registered. tx is driven only from a flop.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_ready=1, tx=1. Acceptance is tx_valid && tx_ready sampled on a rising edge.
- On that acceptance edge:
  - latch tx_data, baud_div, parity_en, parity_odd and two_stop;
  - move to START, tx<=0, tx_ready<=0, tx_busy<=1.
  - Config inputs changing mid-frame have no effect.
- Bit period: each bit holds tx for exactly baud_div+1 clk cycles.
  - A baud counter loads 0 on entry to each bit and advances on the cycle where count==baud_div.
  - baud_div=0 gives 1 cycle per bit.
- START -> DATA. Bits go out LSB first: bit index 0..DATA_BITS-1.
- DATA -> PARITY if parity_en, else -> STOP.
- Parity bit value:
  - even parity: XOR of the latched data;
  - odd parity: its inverse.
- STOP: tx=1 for one bit period, or two if two_stop.
- At the end of the final stop bit:
  - state->IDLE, tx_ready<=1, tx_busy<=0;
  - tx_done<=1 for exactly one cycle;
  - tx remains 1.
- Frame length from acceptance edge to tx_done assertion = (1 + DATA_BITS + parity_en + 1 + two_stop) × (baud_div+1) cycles.
- Back-to-back operation: tx_valid held high is accepted on the first IDLE cycle. This gives a minimum of one extra idle-high cycle between frames beyond the stop bits.
- tx_valid while tx_ready=0 is ignored. The upstream holds tx_data stable until acceptance.
- tx_valid deasserting before acceptance is permitted. Nothing is sent.
- Reset asserted mid-frame:
  - immediately tx=1, tx_ready=1, tx_busy=0, tx_done=0;
  - the frame is aborted with no partial completion pulse.
  - After release, the block is in IDLE.
- tx_busy is the inverse of tx_ready at all times.
- Simulation assertions:
  - DATA_BITS in 5..8;
  - tx_done never high while tx_busy=1;
  - tx never 0 while in IDLE.

Test Plan:
- Reset check: rst_n low, then release -> tx=1, tx_ready=1, tx_busy=0, tx_done=0 before any stimulus.
- Basic 8N1 frame: baud_div=3, parity_en=0, two_stop=0, send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. tx_done pulses 40 cycles after the acceptance edge, width 1.
- Parity and two stop bits, 8E2 then 8O2: baud_div=1, send 0x07, parity_en=1, two_stop=1.
  - Even parity gives parity bit 1, odd gives 0.
  - Each frame is 12 bits × 2 = 24 cycles.
- Back-to-back frames: tx_valid held high with 0x55 then 0x0F at baud_div=0 -> exactly one idle-high cycle between stop and next start. Both bytes decode correctly and there are two tx_done pulses.
- Config change mid-frame: start 0x3C at baud_div=2, then change baud_div to 7 and parity_en to 1 during DATA -> frame completes at 3 cycles/bit with no parity. The next frame uses the new config.
- Reset mid-frame: assert rst_n during DATA bit 4 -> tx=1 in the same cycle, no tx_done. A new byte 0x81 after release transmits correctly.
